// File: rtl/pipe_stage_register_if.sv
// Handshake and data bundle for one pipeline stage boundary.
// The upstream/hazard/downstream side drives through the master modport,
// and the stage register itself sits on the slave modport.
interface pipe_stage_register_if #(
    parameter int DATA_W = 96,
    parameter int CTRL_W = 16,
    parameter int CNT_W  = 16
);
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic [CTRL_W-1:0] in_ctrl;
    logic              in_stall;
    logic              in_flush;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic [CTRL_W-1:0] out_ctrl;
    logic [CNT_W-1:0]  out_stall_cnt;

    modport master (
        output in_valid, in_data, in_ctrl, in_stall, in_flush, out_ready,
        input  in_ready, out_valid, out_data, out_ctrl, out_stall_cnt
    );

    modport slave (
        input  in_valid, in_data, in_ctrl, in_stall, in_flush, out_ready,
        output in_ready, out_valid, out_data, out_ctrl, out_stall_cnt
    );
endinterface

// File: rtl/pipe_stage_register.sv
// Generic pipeline stage register: one cycle of latency, valid/ready
// handshake, synchronous flush, bubble-or-hold stall behaviour and a
// saturating stall-cycle counter.
// Optional feature: define PIPE_SKID_EN to add a one-entry skid buffer so
// that out_ready no longer reaches in_ready combinationally.
module pipe_stage_register #(
    parameter int DATA_W          = 96,
    parameter int CTRL_W          = 16,
    parameter int BUBBLE_ON_STALL = 1,
    parameter int CNT_W           = 16
) (
    input logic                  clk,
    input logic                  reset,
    pipe_stage_register_if.slave bus
);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    // Counter increment that sticks at the all-ones value.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        return (c == CNT_MAX) ? c : c + CNT_W'(1);
    endfunction

    // Control value left behind when the main entry leaves without a
    // replacement: zeroed in bubble mode, kept as-is in hold mode.
    function automatic logic [CTRL_W-1:0] vacate_ctrl(input logic [CTRL_W-1:0] c);
        return (BUBBLE_ON_STALL != 0) ? '0 : c;
    endfunction

    logic              v_q, v_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic [CTRL_W-1:0] ctrl_q, ctrl_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              in_ready;
    logic              transfer;
    logic              consume;
`ifdef PIPE_SKID_EN
    logic              sv_q, sv_d;
    logic [DATA_W-1:0] sdata_q, sdata_d;
    logic [CTRL_W-1:0] sctrl_q, sctrl_d;
`endif

    // Acceptance depends only on stall/flush and on whether there is room.
`ifdef PIPE_SKID_EN
    assign in_ready = !sv_q && !bus.in_stall && !bus.in_flush;
`else
    assign in_ready = !bus.in_flush && !bus.in_stall && (!v_q || bus.out_ready);
`endif
    assign transfer = bus.in_valid && in_ready;
    assign consume  = v_q && bus.out_ready;

    // Next-state for the entry (or entries); flush beats stall beats normal.
    // transfer is already zero under stall or flush, so the stall case
    // only differs from normal by vacating an empty/consumed main entry.
    always_comb begin
        v_d    = v_q;
        data_d = data_q;
        ctrl_d = ctrl_q;
`ifdef PIPE_SKID_EN
        sv_d    = sv_q;
        sdata_d = sdata_q;
        sctrl_d = sctrl_q;
`endif
        if (bus.in_flush) begin
            v_d    = 1'b0;
            ctrl_d = '0;
`ifdef PIPE_SKID_EN
            sv_d    = 1'b0;
            sctrl_d = '0;
`endif
        end else if (!v_q || consume) begin
`ifdef PIPE_SKID_EN
            if (sv_q) begin
                // Older skid entry advances first to keep ordering.
                v_d    = 1'b1;
                data_d = sdata_q;
                ctrl_d = sctrl_q;
                sv_d   = 1'b0;
            end else
`endif
            if (transfer) begin
                v_d    = 1'b1;
                data_d = bus.in_data;
                ctrl_d = bus.in_ctrl;
            end else if (consume || bus.in_stall) begin
                v_d    = 1'b0;
                ctrl_d = vacate_ctrl(ctrl_q);
            end
        end else begin
`ifdef PIPE_SKID_EN
            // Main entry is stuck downstream: park the new arrival.
            if (transfer) begin
                sv_d    = 1'b1;
                sdata_d = bus.in_data;
                sctrl_d = bus.in_ctrl;
            end
`endif
        end
    end

    // Stall counter keeps counting through flush; only reset clears it.
    always_comb begin
        cnt_d = bus.in_stall ? sat_inc(cnt_q) : cnt_q;
    end

    // State registers with synchronous active-high reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            v_q    <= 1'b0;
            data_q <= '0;
            ctrl_q <= '0;
            cnt_q  <= '0;
`ifdef PIPE_SKID_EN
            sv_q    <= 1'b0;
            sdata_q <= '0;
            sctrl_q <= '0;
`endif
        end else begin
            v_q    <= v_d;
            data_q <= data_d;
            ctrl_q <= ctrl_d;
            cnt_q  <= cnt_d;
`ifdef PIPE_SKID_EN
            sv_q    <= sv_d;
            sdata_q <= sdata_d;
            sctrl_q <= sctrl_d;
`endif
        end
    end

    assign bus.in_ready      = in_ready;
    assign bus.out_valid     = v_q;
    assign bus.out_data      = data_q;
    assign bus.out_ctrl      = ctrl_q;
    assign bus.out_stall_cnt = cnt_q;
endmodule

// File: tb/tb_pipe_stage_register.sv
// Bench for pipe_stage_register: a bubble-mode instance with 96-bit payload
// driven by directed and random traffic against an occupancy/queue model,
// plus a hold-mode instance with a 4-bit counter for hold and saturation.
module tb_pipe_stage_register;
    logic clk;
    logic rst0;
    logic rst1;
    int   total;
    int   bad;

    typedef struct packed {
        logic [15:0] c;
        logic [95:0] d;
    } ent_t;

    ent_t        exp_q[$];
    ent_t        mon_e;
    int          occ;
    int          cnt0;
    logic [95:0] last_data;

    pipe_stage_register_if #(.DATA_W(96), .CTRL_W(16), .CNT_W(16)) b0 ();
    pipe_stage_register_if #(.DATA_W(32), .CTRL_W(16), .CNT_W(4))  b1 ();

    pipe_stage_register #(.DATA_W(96), .CTRL_W(16), .BUBBLE_ON_STALL(1), .CNT_W(16)) dut0 (
        .clk(clk), .reset(rst0), .bus(b0)
    );
    pipe_stage_register #(.DATA_W(32), .CTRL_W(16), .BUBBLE_ON_STALL(0), .CNT_W(4)) dut1 (
        .clk(clk), .reset(rst1), .bus(b1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic void chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endfunction

    // Monitor: every consumption on dut0 must match the oldest accepted entry.
    always @(negedge clk) begin
        #2;
        if (!rst0 && b0.out_valid && b0.out_ready) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL mon_unexpected: got data %0h, expected no output", b0.out_data);
            end else begin
                mon_e = exp_q.pop_front();
                chk("mon_data", 128'(b0.out_data), 128'(mon_e.d));
                chk("mon_ctrl", 128'(b0.out_ctrl), 128'(mon_e.c));
            end
        end
    end

    // One cycle on dut0: check registered outputs, drive, check in_ready,
    // then advance the model (entries pending, last data seen, stall count).
    task automatic cycle0(input logic v, input logic [95:0] d, input logic [15:0] c,
                          input logic st, input logic fl, input logic ordy);
        logic rdy_m;
        logic cons;
        ent_t ne;
        @(negedge clk);
        chk("out_valid", 128'(b0.out_valid), 128'(occ != 0));
        if (occ != 0 && exp_q.size() != 0) begin
            chk("out_data", 128'(b0.out_data), 128'(exp_q[0].d));
            chk("out_ctrl", 128'(b0.out_ctrl), 128'(exp_q[0].c));
        end else begin
            chk("idle_data", 128'(b0.out_data), 128'(last_data));
            chk("idle_ctrl", 128'(b0.out_ctrl), 128'(0));
        end
        chk("stall_cnt", 128'(b0.out_stall_cnt), 128'(cnt0));
        b0.in_valid  = v;
        b0.in_data   = d;
        b0.in_ctrl   = c;
        b0.in_stall  = st;
        b0.in_flush  = fl;
        b0.out_ready = ordy;
        #1;
`ifdef PIPE_SKID_EN
        rdy_m = !fl && !st && (occ < 2);
`else
        rdy_m = !fl && !st && (occ == 0 || ordy);
`endif
        chk("in_ready", 128'(b0.in_ready), 128'(rdy_m));
        cons = (occ != 0) && ordy;
        if (fl) begin
            if (occ != 0 && exp_q.size() != 0) last_data = exp_q[0].d;
            if (cons) begin
                while (exp_q.size() > 1) void'(exp_q.pop_back());
            end else begin
                exp_q.delete();
            end
            occ = 0;
        end else begin
            if (cons) occ--;
            if (v && rdy_m) begin
                ne.c = c;
                ne.d = d;
                exp_q.push_back(ne);
                occ++;
                last_data = d;
            end
        end
        if (st && cnt0 < 65535) cnt0++;
    endtask

    // Reset dut0 while an input is being offered; everything must read zero.
    task automatic reset0();
        @(negedge clk);
        rst0         = 1'b1;
        b0.in_valid  = 1'b1;
        b0.in_data   = 96'h99;
        b0.in_ctrl   = 16'h5A;
        b0.in_stall  = 1'b0;
        b0.in_flush  = 1'b0;
        b0.out_ready = 1'b0;
        @(posedge clk);
        #1;
        rst0 = 1'b0;
        exp_q.delete();
        occ       = 0;
        cnt0      = 0;
        last_data = '0;
        chk("rst_valid", 128'(b0.out_valid), 128'(0));
        chk("rst_data", 128'(b0.out_data), 128'(0));
        chk("rst_ctrl", 128'(b0.out_ctrl), 128'(0));
        chk("rst_cnt", 128'(b0.out_stall_cnt), 128'(0));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        total = 0;
        bad   = 0;
        occ   = 0;
        cnt0  = 0;
        last_data = '0;
        rst0 = 1'b1;
        rst1 = 1'b1;
        b0.in_valid = 1'b0; b0.in_data = '0; b0.in_ctrl = '0;
        b0.in_stall = 1'b0; b0.in_flush = 1'b0; b0.out_ready = 1'b0;
        b1.in_valid = 1'b0; b1.in_data = '0; b1.in_ctrl = '0;
        b1.in_stall = 1'b0; b1.in_flush = 1'b0; b1.out_ready = 1'b0;
        repeat (2) @(posedge clk);
        reset0();

        // Back-to-back stream with downstream always ready.
        cycle0(1'b1, 96'd1, 16'h0011, 1'b0, 1'b0, 1'b1);
        cycle0(1'b1, 96'd2, 16'h0022, 1'b0, 1'b0, 1'b1);
        cycle0(1'b1, 96'd3, 16'h0033, 1'b0, 1'b0, 1'b1);
        cycle0(1'b0, 96'd0, 16'h0000, 1'b0, 1'b0, 1'b1);
        cycle0(1'b0, 96'd0, 16'h0000, 1'b0, 1'b0, 1'b1);

        // Stall in bubble mode after one entry.
        reset0();
        cycle0(1'b1, 96'hA5A5, 16'h00FF, 1'b0, 1'b0, 1'b1);
        repeat (3) cycle0(1'b0, 96'd0, 16'h0000, 1'b1, 1'b0, 1'b1);
        @(posedge clk);
        #1;
        chk("bub_valid", 128'(b0.out_valid), 128'(0));
        chk("bub_ctrl", 128'(b0.out_ctrl), 128'(0));
        chk("bub_data", 128'(b0.out_data), 128'(96'hA5A5));
        chk("bub_cnt", 128'(b0.out_stall_cnt), 128'(3));

        // Flush together with stall and a valid offer.
        cycle0(1'b1, 96'h1234, 16'h0F0F, 1'b0, 1'b0, 1'b0);
        cycle0(1'b0, 96'd0, 16'h0000, 1'b0, 1'b0, 1'b0);
        k = cnt0;
        cycle0(1'b1, 96'h5555, 16'hFFFF, 1'b1, 1'b1, 1'b0);
        @(posedge clk);
        #1;
        chk("fl_valid", 128'(b0.out_valid), 128'(0));
        chk("fl_ctrl", 128'(b0.out_ctrl), 128'(0));
        chk("fl_data", 128'(b0.out_data), 128'(96'h1234));
        chk("fl_cnt", 128'(b0.out_stall_cnt), 128'(k + 1));

`ifdef PIPE_SKID_EN
        // Two offers absorbed while blocked, third refused, then in-order drain.
        cycle0(1'b1, 96'd7, 16'h0007, 1'b0, 1'b0, 1'b0);
        cycle0(1'b1, 96'd8, 16'h0008, 1'b0, 1'b0, 1'b0);
        cycle0(1'b1, 96'd9, 16'h0009, 1'b0, 1'b0, 1'b0);
        repeat (3) cycle0(1'b0, 96'd0, 16'h0000, 1'b0, 1'b0, 1'b1);
`endif

        // Random traffic with a reset in the middle.
        for (int i = 0; i < 400; i++) begin
            if (i == 200) reset0();
            cycle0(($urandom_range(0, 3) != 0), {$urandom, $urandom, $urandom}, 16'($urandom),
                   ($urandom_range(0, 7) == 0), ($urandom_range(0, 19) == 0),
                   ($urandom_range(0, 9) < 7));
        end
        repeat (4) cycle0(1'b0, 96'd0, 16'h0000, 1'b0, 1'b0, 1'b1);
        @(negedge clk);
        #3;
        chk("drain_empty", 128'(exp_q.size()), 128'(0));

        // Hold-mode instance: hold under stall, then counter saturation.
        @(negedge clk);
        rst1 = 1'b0;
        chk("d1_rst_valid", 128'(b1.out_valid), 128'(0));
        chk("d1_rst_cnt", 128'(b1.out_stall_cnt), 128'(0));
        b1.in_valid  = 1'b1;
        b1.in_data   = 32'h77;
        b1.in_ctrl   = 16'hABCD;
        b1.out_ready = 1'b0;
        #1;
        chk("d1_ready_idle", 128'(b1.in_ready), 128'(1));
        @(negedge clk);
        b1.in_data  = 32'h88;
        b1.in_stall = 1'b1;
        #1;
        chk("d1_ready_stall", 128'(b1.in_ready), 128'(0));
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            chk("d1_hold_valid", 128'(b1.out_valid), 128'(1));
            chk("d1_hold_ctrl", 128'(b1.out_ctrl), 128'(16'hABCD));
            chk("d1_hold_data", 128'(b1.out_data), 128'(32'h77));
            chk("d1_cnt", 128'(b1.out_stall_cnt), 128'((i + 1 > 15) ? 15 : i + 1));
        end
        b1.in_stall  = 1'b0;
        b1.in_valid  = 1'b0;
        b1.out_ready = 1'b1;
        #1;
        chk("d1_ready_release", 128'(b1.in_ready), 128'(1));
        @(negedge clk);
        chk("d1_cons_valid", 128'(b1.out_valid), 128'(0));
        chk("d1_cons_ctrl", 128'(b1.out_ctrl), 128'(16'hABCD));
        chk("d1_cons_data", 128'(b1.out_data), 128'(32'h77));
        chk("d1_cnt_sat", 128'(b1.out_stall_cnt), 128'(15));
        rst1 = 1'b1;
        @(negedge clk);
        rst1 = 1'b0;
        chk("d1_rst2_cnt", 128'(b1.out_stall_cnt), 128'(0));
        chk("d1_rst2_ctrl", 128'(b1.out_ctrl), 128'(0));
        chk("d1_rst2_data", 128'(b1.out_data), 128'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
